// File: rtl/instruction_fetch_queue.sv
// Fetch front-end: owns the fetch PC and prefetches ROM words into a small
// circular queue of {instruction, pc+4} so decode can stall without losing fetched words.
module instruction_fetch_queue #(
    parameter int unsigned  DEPTH    = 4,
    parameter logic [31:0]  RESET_PC = 32'h0040_0000,
    localparam int unsigned PTR_W    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    output logic [31:0]      rom_address_o,
    input  logic [31:0]      rom_instruction_i,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [31:0]      redirect_pc_i,
    output logic             instr_valid_o,
    output logic [31:0]      instr_o,
    output logic [31:0]      pc_plus_4_o,
    output logic [PTR_W:0]   count_o,
    output logic             misaligned_o
);

    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    logic [31:0]      fetch_pc_r;
    logic [31:0]      fetch_pc_next;
    logic [31:0]      instr_mem [DEPTH];
    logic [31:0]      pc4_mem   [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             misaligned_r;

    logic head_valid;
    logic full;
    logic pop;
    logic push;

    // Handshake toward decode: a head word is consumed on any cycle where
    // instr_valid_o=1 and stall_i=0 (no redirect); stall_i holds the head.
    // Pushing into a full queue is allowed only when the head leaves that cycle.
    always_comb begin
        head_valid    = (count_r != '0);
        full          = (count_r == FULL_COUNT);
        pop           = head_valid & ~stall_i & ~redirect_i;
        push          = ~redirect_i & (~full | pop);
        fetch_pc_next = fetch_pc_r + 32'd4;
    end

    assign rom_address_o = fetch_pc_r;
    assign instr_valid_o = head_valid;
    assign instr_o       = head_valid ? instr_mem[rd_ptr_r] : 32'h0;
    assign pc_plus_4_o   = head_valid ? pc4_mem[rd_ptr_r]   : 32'h0;
    assign count_o       = count_r;
    assign misaligned_o  = misaligned_r;

    // Storage carries no reset; validity is tracked by count_r alone.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            instr_mem[wr_ptr_r] <= rom_instruction_i;
            pc4_mem[wr_ptr_r]   <= fetch_pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r   <= RESET_PC;
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= '0;
            misaligned_r <= 1'b0;
        end else if (redirect_i) begin
            fetch_pc_r   <= {redirect_pc_i[31:2], 2'b00};
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= '0;
            misaligned_r <= |redirect_pc_i[1:0];
        end else begin
            misaligned_r <= 1'b0;
            if (push) begin
                wr_ptr_r   <= wr_ptr_r + PTR_ONE;
                fetch_pc_r <= fetch_pc_next;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + COUNT_ONE;
                2'b01:   count_r <= count_r - COUNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Bench for instruction_fetch_queue: ROM returns word = address, a negedge
// scoreboard tracks the expected fetch stream, and directed tasks check the key scenarios.
module tb_instruction_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam int          CW       = $clog2(DEPTH) + 1;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic          clk;
    logic          reset;
    logic [31:0]   rom_address;
    logic [31:0]   rom_instruction;
    logic          stall;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          instr_valid;
    logic [31:0]   instr;
    logic [31:0]   pc_plus_4;
    logic [CW-1:0] count;
    logic          misaligned;

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboard state: addresses of words expected in the queue, oldest first.
    logic [31:0] exp_q[$];
    logic [31:0] m_pc  = RESET_PC;
    logic        m_mis = 1'b0;
    logic        m_init = 1'b0;

    instruction_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk               (clk),
        .reset             (reset),
        .rom_address_o     (rom_address),
        .rom_instruction_i (rom_instruction),
        .stall_i           (stall),
        .redirect_i        (redirect),
        .redirect_pc_i     (redirect_pc),
        .instr_valid_o     (instr_valid),
        .instr_o           (instr),
        .pc_plus_4_o       (pc_plus_4),
        .count_o           (count),
        .misaligned_o      (misaligned)
    );

    assign rom_instruction = rom_address;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard: compare the DUT against the expected queue, then advance the
    // model with the inputs that the coming rising edge will see.
    always @(negedge clk) begin
        logic [31:0] head;
        logic [31:0] head_p4;
        logic        do_pop;
        logic        do_push;
        if (m_init) begin
            n_cmp++;
            if (count !== CW'(exp_q.size())) begin
                n_bad++;
                $display("FAIL sb_count t=%0t got %0d exp %0d", $time, count, exp_q.size());
            end
            n_cmp++;
            if (rom_address !== m_pc) begin
                n_bad++;
                $display("FAIL sb_rom_address t=%0t got %h exp %h", $time, rom_address, m_pc);
            end
            n_cmp++;
            if (misaligned !== m_mis) begin
                n_bad++;
                $display("FAIL sb_misaligned t=%0t got %b exp %b", $time, misaligned, m_mis);
            end
            if (exp_q.size() != 0) begin
                head    = exp_q[0];
                head_p4 = head + 32'd4;
                n_cmp++;
                if (instr_valid !== 1'b1 || instr !== head || pc_plus_4 !== head_p4) begin
                    n_bad++;
                    $display("FAIL sb_head t=%0t got v=%b i=%h p=%h exp v=1 i=%h p=%h",
                             $time, instr_valid, instr, pc_plus_4, head, head_p4);
                end
            end else begin
                n_cmp++;
                if (instr_valid !== 1'b0 || instr !== 32'h0 || pc_plus_4 !== 32'h0) begin
                    n_bad++;
                    $display("FAIL sb_empty t=%0t got v=%b i=%h p=%h exp v=0 i=0 p=0",
                             $time, instr_valid, instr, pc_plus_4);
                end
            end
        end
        if (reset) begin
            exp_q.delete();
            m_pc   = RESET_PC;
            m_mis  = 1'b0;
            m_init = 1'b1;
        end else if (m_init) begin
            if (redirect) begin
                exp_q.delete();
                m_pc  = {redirect_pc[31:2], 2'b00};
                m_mis = (redirect_pc[1:0] != 2'b00);
            end else begin
                m_mis   = 1'b0;
                do_pop  = (exp_q.size() != 0) && !stall;
                do_push = (exp_q.size() < DEPTH) || do_pop;
                if (do_pop) void'(exp_q.pop_front());
                if (do_push) begin
                    exp_q.push_back(m_pc);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        cyc(2);
        n_cmp++;
        if (count !== '0 || instr_valid !== 1'b0 || instr !== 32'h0 || pc_plus_4 !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_outputs got c=%0d v=%b i=%h p=%h exp 0/0/0/0", count, instr_valid, instr, pc_plus_4);
        end
        n_cmp++;
        if (rom_address !== 32'h0040_0000 || misaligned !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_pc got a=%h m=%b exp a=00400000 m=0", rom_address, misaligned);
        end
        reset = 1'b0;
    endtask

    task automatic test_stream();
        cyc();
        n_cmp++;
        if (instr_valid !== 1'b1 || instr !== 32'h0040_0000 || pc_plus_4 !== 32'h0040_0004 || count !== CW'(1)) begin
            n_bad++;
            $display("FAIL first_fetch got v=%b i=%h p=%h c=%0d exp 1/00400000/00400004/1", instr_valid, instr, pc_plus_4, count);
        end
        for (int k = 1; k <= 4; k++) begin
            cyc();
            n_cmp++;
            if (instr !== RESET_PC + 32'(4 * k) || count !== CW'(1)) begin
                n_bad++;
                $display("FAIL stream_%0d got i=%h c=%0d exp i=%h c=1", k, instr, count, RESET_PC + 32'(4 * k));
            end
        end
    endtask

    // Entered with head 0x00400010, count 1.
    task automatic test_stall();
        stall = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            n_cmp++;
            if (count !== CW'((k + 1 > DEPTH) ? DEPTH : k + 1) || instr !== 32'h0040_0010) begin
                n_bad++;
                $display("FAIL stall_fill_%0d got c=%0d i=%h exp c=%0d i=00400010", k, count, instr, (k + 1 > DEPTH) ? DEPTH : k + 1);
            end
        end
        n_cmp++;
        if (rom_address !== 32'h0040_0020) begin
            n_bad++;
            $display("FAIL stall_freeze got a=%h exp 00400020", rom_address);
        end
    endtask

    task automatic test_full_pushpop();
        stall = 1'b0;
        cyc();
        n_cmp++;
        if (count !== CW'(DEPTH) || rom_address !== 32'h0040_0024 || instr !== 32'h0040_0014) begin
            n_bad++;
            $display("FAIL full_pushpop got c=%0d a=%h i=%h exp c=4 a=00400024 i=00400014", count, rom_address, instr);
        end
        cyc(6);
        n_cmp++;
        if (instr !== 32'h0040_002C || count !== CW'(DEPTH)) begin
            n_bad++;
            $display("FAIL drain_order got i=%h c=%0d exp i=0040002c c=4", instr, count);
        end
    endtask

    task automatic test_redirect();
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0040_0300;
        cyc();
        redirect = 1'b0;
        cyc(3);
        n_cmp++;
        if (count !== CW'(3)) begin
            n_bad++;
            $display("FAIL redirect_prefill got c=%0d exp 3", count);
        end
        redirect = 1'b1; redirect_pc = 32'h0040_0100;
        cyc();
        n_cmp++;
        if (count !== '0 || instr_valid !== 1'b0 || rom_address !== 32'h0040_0100 || misaligned !== 1'b0) begin
            n_bad++;
            $display("FAIL redirect_flush got c=%0d v=%b a=%h m=%b exp 0/0/00400100/0", count, instr_valid, rom_address, misaligned);
        end
        redirect = 1'b0; stall = 1'b0;
        cyc();
        n_cmp++;
        if (instr_valid !== 1'b1 || instr !== 32'h0040_0100 || pc_plus_4 !== 32'h0040_0104) begin
            n_bad++;
            $display("FAIL redirect_target got v=%b i=%h p=%h exp 1/00400100/00400104", instr_valid, instr, pc_plus_4);
        end
    endtask

    task automatic test_misaligned();
        redirect = 1'b1; redirect_pc = 32'h0040_0203;
        cyc();
        redirect = 1'b0;
        n_cmp++;
        if (misaligned !== 1'b1 || instr_valid !== 1'b0 || rom_address !== 32'h0040_0200) begin
            n_bad++;
            $display("FAIL misaligned_pulse got m=%b v=%b a=%h exp 1/0/00400200", misaligned, instr_valid, rom_address);
        end
        cyc();
        n_cmp++;
        if (misaligned !== 1'b0 || instr !== 32'h0040_0200) begin
            n_bad++;
            $display("FAIL misaligned_first got m=%b i=%h exp 0/00400200", misaligned, instr);
        end
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cyc();
        redirect = 1'b0;
        cyc();
        n_cmp++;
        if (instr !== 32'hFFFF_FFFC || pc_plus_4 !== 32'h0000_0000) begin
            n_bad++;
            $display("FAIL wrap_top got i=%h p=%h exp fffffffc/00000000", instr, pc_plus_4);
        end
        cyc();
        n_cmp++;
        if (instr !== 32'h0000_0000 || pc_plus_4 !== 32'h0000_0004 || instr_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap_zero got v=%b i=%h p=%h exp 1/00000000/00000004", instr_valid, instr, pc_plus_4);
        end
    endtask

    task automatic test_reset_full();
        stall = 1'b1;
        cyc(4);
        n_cmp++;
        if (count !== CW'(DEPTH)) begin
            n_bad++;
            $display("FAIL prereset_full got c=%0d exp 4", count);
        end
        reset = 1'b1;
        cyc();
        n_cmp++;
        if (count !== '0 || instr_valid !== 1'b0 || rom_address !== RESET_PC || instr !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_full got c=%0d v=%b a=%h i=%h exp 0/0/00400000/0", count, instr_valid, rom_address, instr);
        end
        reset = 1'b0; stall = 1'b0;
        cyc();
        n_cmp++;
        if (instr !== RESET_PC || pc_plus_4 !== 32'h0040_0004) begin
            n_bad++;
            $display("FAIL reset_restart got i=%h p=%h exp 00400000/00400004", instr, pc_plus_4);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            stall       = ($urandom_range(0, 2) == 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = {20'h00400, 10'($urandom_range(0, 1023)), 2'($urandom_range(0, 3))};
            cyc();
        end
        redirect = 1'b0; stall = 1'b0;
        cyc(2);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_full_pushpop();
        test_redirect();
        test_misaligned();
        test_wrap();
        test_reset_full();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
